// File: rtl/recorder_pkg.sv
// Shared types and helpers for the multi-track beat recorder.
package recorder_pkg;

  localparam int REC_PITCH_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2,
    ST_HOLD = 2'd3
  } rec_state_e;

  // Clears everything above the stored pitch width so playback is zero-extended.
  function automatic logic [31:0] zext_pitch(input logic [31:0] raw, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return raw & mask;
  endfunction

endpackage

// File: rtl/track_mem.sv
// One pitch track: synchronous write on the beat tick, asynchronous read at the current position.
module track_mem #(
  parameter int DEPTH   = 512,
  parameter int PITCH_W = 11,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               beat_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [PITCH_W-1:0] wdata_i,
  output logic [PITCH_W-1:0] rdata_o
);

  logic [PITCH_W-1:0] mem_q [DEPTH];

  always_ff @(posedge beat_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/multi_track_recorder.sv
// Multi-track beat recorder: record/overdub one track while the others play, loop or one-shot
// playback, per-track clear.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | pos=0, outputs silent; waits for record/play/clear request
//  REC     | writing track trk at pos, other tracks play back (overdub)
//  PLAY    | all tracks play from pos, up to the longest recorded length
//  HOLD    | playback finished or nothing to play; silent until play_req drops
module multi_track_recorder
  import recorder_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int DEPTH      = 512,
  parameter int PITCH_W    = REC_PITCH_W,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int TRK_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                       beat,
  input  logic                       reset,
  input  logic                       rec_req,
  input  logic                       play_req,
  input  logic                       loop_en,
  input  logic                       clr_req,
  input  logic [TRK_W-1:0]           track_sel,
  input  logic [31:0]                freq,
  output logic [32*NUM_TRACKS-1:0]   freq_out,
  output logic                       recording,
  output logic                       playing,
  output logic [ADDR_W-1:0]          pos,
  output logic                       full
);

  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  rec_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pos_q, pos_d;
  logic [TRK_W-1:0]   trk_q, trk_d;
  logic [ADDR_W:0]    len_q [NUM_TRACKS];
  logic [ADDR_W:0]    len_d [NUM_TRACKS];
  logic [31:0]        fout_q [NUM_TRACKS];
  logic [31:0]        fout_d [NUM_TRACKS];
  logic               full_q, full_d;
  logic               rec_block_q, rec_block_d;

  logic [PITCH_W-1:0] rd_data [NUM_TRACKS];
  logic [31:0]        play_val [NUM_TRACKS];
  logic [NUM_TRACKS-1:0] wr_en;
  logic [ADDR_W:0]    max_len;
  logic               sel_valid;

  assign sel_valid = int'(track_sel) < NUM_TRACKS;

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
    assign wr_en[t] = (state_q == ST_REC) && rec_req && (int'(trk_q) == t);

    track_mem #(
      .DEPTH   (DEPTH),
      .PITCH_W (PITCH_W)
    ) u_mem (
      .beat_i  (beat),
      .we_i    (wr_en[t]),
      .addr_i  (pos_q),
      .wdata_i (freq[PITCH_W-1:0]),
      .rdata_o (rd_data[t])
    );

    assign play_val[t] = ({1'b0, pos_q} < len_q[t]) ? zext_pitch(32'(rd_data[t]), PITCH_W) : 32'd0;
    assign freq_out[32*t +: 32] = fout_q[t];
  end

  always_comb begin
    max_len = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      if (len_q[t] > max_len) max_len = len_q[t];
    end
  end

  // After a take fills the track, rec_req must drop before a new take can start,
  // so a held request cannot silently overwrite the take from position 0.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    trk_d       = trk_q;
    len_d       = len_q;
    full_d      = 1'b0;
    rec_block_d = rec_block_q && rec_req;
    for (int t = 0; t < NUM_TRACKS; t++) fout_d[t] = '0;

    unique case (state_q)
      ST_IDLE: begin
        pos_d = '0;
        if (rec_req && sel_valid && !rec_block_q) begin
          state_d = ST_REC;
          trk_d   = track_sel;
        end else if (play_req) begin
          state_d = (max_len == '0) ? ST_HOLD : ST_PLAY;
        end else if (clr_req && sel_valid) begin
          len_d[track_sel] = '0;
        end
      end

      ST_REC: begin
        for (int t = 0; t < NUM_TRACKS; t++) begin
          fout_d[t] = (int'(trk_q) == t) ? 32'd0 : play_val[t];
        end
        if (!rec_req) begin
          len_d[trk_q] = {1'b0, pos_q};
          state_d      = ST_IDLE;
          pos_d        = '0;
        end else if (pos_q == ADDR_W'(DEPTH - 1)) begin
          len_d[trk_q] = (ADDR_W + 1)'(DEPTH);
          full_d       = 1'b1;
          rec_block_d  = 1'b1;
          state_d      = ST_IDLE;
          pos_d        = '0;
        end else begin
          pos_d = pos_q + ADDR_W'(1);
        end
      end

      ST_PLAY: begin
        if (!play_req) begin
          state_d = ST_IDLE;
          pos_d   = '0;
        end else begin
          for (int t = 0; t < NUM_TRACKS; t++) fout_d[t] = play_val[t];
          if ({1'b0, pos_q} == max_len - LEN_ONE) begin
            pos_d = '0;
            if (!loop_en) state_d = ST_HOLD;
          end else begin
            pos_d = pos_q + ADDR_W'(1);
          end
        end
      end

      ST_HOLD: begin
        pos_d = '0;
        if (!play_req) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge beat or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      trk_q       <= '0;
      full_q      <= 1'b0;
      rec_block_q <= 1'b0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        len_q[t]  <= '0;
        fout_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      trk_q       <= trk_d;
      full_q      <= full_d;
      rec_block_q <= rec_block_d;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        len_q[t]  <= len_d[t];
        fout_q[t] <= fout_d[t];
      end
    end
  end

  assign recording = (state_q == ST_REC);
  assign playing   = (state_q == ST_PLAY);
  assign pos       = pos_q;
  assign full      = full_q;

endmodule

// File: tb/tb_multi_track_recorder.sv
// Directed bench for multi_track_recorder (4 tracks, DEPTH=8) with hand-computed expectations.
module tb_multi_track_recorder;

  localparam int NT = 4;
  localparam int DP = 8;

  logic          beat;
  logic          reset;
  logic          rec_req, play_req, loop_en, clr_req;
  logic [1:0]    track_sel;
  logic [31:0]   freq;
  logic [32*NT-1:0] freq_out;
  logic          recording, playing, full;
  logic [2:0]    pos;

  int n_checks = 0;
  int n_pass   = 0;

  multi_track_recorder #(
    .NUM_TRACKS (NT),
    .DEPTH      (DP),
    .PITCH_W    (11)
  ) dut (
    .beat      (beat),
    .reset     (reset),
    .rec_req   (rec_req),
    .play_req  (play_req),
    .loop_en   (loop_en),
    .clr_req   (clr_req),
    .track_sel (track_sel),
    .freq      (freq),
    .freq_out  (freq_out),
    .recording (recording),
    .playing   (playing),
    .pos       (pos),
    .full      (full)
  );

  initial beat = 1'b0;
  always #5 beat = ~beat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] fo(input int t);
    return freq_out[32*t +: 32];
  endfunction

  task automatic tick();
    @(posedge beat);
    #1;
  endtask

  int exp0_od [5] = '{262, 294, 330, 0, 0};
  int od_val  [5] = '{440, 494, 523, 587, 659};
  int loop_ex [7] = '{262, 294, 330, 262, 294, 330, 262};
  int loop_ps [7] = '{1, 2, 0, 1, 2, 0, 1};

  initial begin
    reset = 1'b0; rec_req = 0; play_req = 0; loop_en = 0; clr_req = 0;
    track_sel = '0; freq = '0;
    #12;
    check("rst_recording", recording, 0);
    check("rst_playing", playing, 0);
    check("rst_pos", pos, 0);
    check("rst_full", full, 0);
    check("rst_fo0", fo(0), 0);
    reset = 1'b1;

    // record 262,294,330 on track 0
    rec_req = 1; track_sel = 0; freq = 262;
    tick();
    check("t1_rec_enter", recording, 1);
    check("t1_pos0", pos, 0);
    tick();
    freq = 294; tick();
    freq = 330; tick();
    check("t1_pos3", pos, 3);
    rec_req = 0; tick();
    check("t1_rec_exit", recording, 0);
    play_req = 1; tick();
    check("t1_play_enter", playing, 1);
    tick(); check("t1_fo0_a", fo(0), 262);
    tick(); check("t1_fo0_b", fo(0), 294);
    tick(); check("t1_fo0_c", fo(0), 330);
    check("t1_hold", playing, 0);
    tick(); check("t1_hold_fo0", fo(0), 0);
    play_req = 0; tick();

    // overdub track 1 while track 0 plays; track_sel change mid-take is ignored
    rec_req = 1; track_sel = 1; tick();
    for (int i = 0; i < 5; i++) begin
      freq = od_val[i];
      if (i == 2) track_sel = 3;
      tick();
      check("t2_od_fo0", fo(0), exp0_od[i]);
      check("t2_od_fo1", fo(1), 0);
    end
    rec_req = 0; tick();
    play_req = 1; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_play_fo0", fo(0), exp0_od[i]);
      check("t2_play_fo1", fo(1), od_val[i]);
      check("t2_play_fo3", fo(3), 0);
    end
    check("t2_hold", playing, 0);
    play_req = 0; tick();

    // clear track 1, playback shows only track 0
    clr_req = 1; track_sel = 1; tick();
    clr_req = 0;
    play_req = 1; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_fo0", fo(0), exp0_od[i]);
      check("t6_fo1", fo(1), 0);
    end
    check("t6_hold", playing, 0);
    play_req = 0; tick();

    // seamless loop of a 3-beat track
    loop_en = 1; play_req = 1; tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t3_loop_fo0", fo(0), loop_ex[i]);
      check("t3_loop_pos", pos, loop_ps[i]);
      check("t3_loop_playing", playing, 1);
    end
    play_req = 0; tick();
    check("t3_stop_fo0", fo(0), 0);
    check("t3_stop_playing", playing, 0);
    loop_en = 0;

    // record wins over play; zero-beat take on track 2
    rec_req = 1; play_req = 1; track_sel = 2; tick();
    check("t6_rec_wins", recording, 1);
    check("t6_not_playing", playing, 0);
    rec_req = 0; play_req = 0; tick();
    check("t6_rec_done", recording, 0);

    // fill track 3 to DEPTH while holding rec_req for DEPTH+2 beats
    rec_req = 1; track_sel = 3; tick();
    for (int i = 0; i < DP; i++) begin
      freq = 100 + i;
      tick();
      check("t4_full", full, (i == DP - 1) ? 1 : 0);
    end
    check("t4_idle_after_full", recording, 0);
    freq = 999;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_no_rearm", recording, 0);
      check("t4_full_pulse", full, 0);
    end
    rec_req = 0; tick();
    play_req = 1; tick();
    for (int i = 0; i < DP; i++) begin
      tick();
      check("t4_play_fo3", fo(3), 100 + i);
      check("t4_play_fo0", fo(0), (i < 3) ? exp0_od[i] : 0);
    end
    check("t4_hold", playing, 0);
    play_req = 0; tick();

    // asynchronous reset mid-PLAY
    play_req = 1; tick(); tick();
    check("t5_pre_fo0", fo(0), 262);
    #2 reset = 0;
    #1;
    check("t5_play_rst_fo0", fo(0), 0);
    check("t5_play_rst_playing", playing, 0);
    check("t5_play_rst_pos", pos, 0);
    play_req = 0; reset = 1;

    // asynchronous reset mid-REC, then play finds nothing and holds
    rec_req = 1; track_sel = 0; freq = 500; tick(); tick(); tick();
    check("t5_pre_pos", pos, 2);
    #2 reset = 0;
    #1;
    check("t5_rec_rst_recording", recording, 0);
    check("t5_rec_rst_pos", pos, 0);
    rec_req = 0; reset = 1;
    play_req = 1; tick();
    check("t5_hold_playing", playing, 0);
    check("t5_hold_recording", recording, 0);
    tick();
    check("t5_hold_fo0", fo(0), 0);
    check("t5_hold_fo3", fo(3), 0);
    play_req = 0; tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
